// File: rtl/result_readback_ctrl_pkg.sv
// Shared constants and FSM state encoding for the result SRAM readback path.
package result_readback_ctrl_pkg;

  localparam int ADDRESSSIZE    = 10;
  localparam int PARTIAL_SUM_BW = 24;
  localparam int MATRIX_SIZE    = 16;
  localparam int LANE_BW        = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_STREAM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/result_lane_serializer.sv
// Holds one fetched SRAM row and presents it lane by lane, lane 0 first.
module result_lane_serializer #(
  parameter int PARTIAL_SUM_BW = 24,
  parameter int MATRIX_SIZE    = 16,
  parameter int LANE_BW        = 4
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   capture,
  input  logic                                   advance,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  row_data,
  output logic [PARTIAL_SUM_BW-1:0]              lane_data,
  output logic [LANE_BW-1:0]                     lane,
  output logic                                   lane_wrap
);

  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] row_reg;

  // The lane counter wraps naturally because MATRIX_SIZE is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_reg <= '0;
      lane    <= '0;
    end else if (capture) begin
      row_reg <= row_data;
      lane    <= '0;
    end else if (advance) begin
      lane    <= lane + 1'b1;
    end
  end

  assign lane_data = row_reg[lane*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
  assign lane_wrap = (lane == LANE_BW'(MATRIX_SIZE - 1));

endmodule

// File: rtl/result_readback_ctrl.sv
// Reads num_rows result rows from base_addr and streams them out one lane per beat.
module result_readback_ctrl #(
  parameter int ADDRESSSIZE    = result_readback_ctrl_pkg::ADDRESSSIZE,
  parameter int PARTIAL_SUM_BW = result_readback_ctrl_pkg::PARTIAL_SUM_BW,
  parameter int MATRIX_SIZE    = result_readback_ctrl_pkg::MATRIX_SIZE,
  parameter int LANE_BW        = result_readback_ctrl_pkg::LANE_BW
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   start,
  input  logic [ADDRESSSIZE-1:0]                 base_addr,
  input  logic [ADDRESSSIZE:0]                   num_rows,
  output logic                                   sram_read_en,
  output logic [ADDRESSSIZE-1:0]                 sram_address,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  sram_rdata,
  output logic [PARTIAL_SUM_BW-1:0]              out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LANE_BW-1:0]                     out_lane,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done
);

  import result_readback_ctrl_pkg::*;

  localparam logic [ADDRESSSIZE:0] ONE_ROW = (ADDRESSSIZE+1)'(1);

  state_t                 state;
  logic [ADDRESSSIZE-1:0] addr_reg;
  logic [ADDRESSSIZE:0]   rows_left;
  logic                   lane_wrap;
  logic                   transfer;

  assign transfer = out_valid && out_ready;

  result_lane_serializer #(
    .PARTIAL_SUM_BW (PARTIAL_SUM_BW),
    .MATRIX_SIZE    (MATRIX_SIZE),
    .LANE_BW        (LANE_BW)
  ) u_serializer (
    .clk       (clk),
    .rstn      (rstn),
    .capture   (state == ST_CAPTURE),
    .advance   (transfer),
    .row_data  (sram_rdata),
    .lane_data (out_data),
    .lane      (out_lane),
    .lane_wrap (lane_wrap)
  );

  assign out_last = out_valid && (rows_left == ONE_ROW) && lane_wrap;

  // Outputs are registered on the transition into the state that owns them,
  // so sram_address only moves when a new READ is entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      addr_reg     <= '0;
      rows_left    <= '0;
      sram_read_en <= 1'b0;
      sram_address <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      sram_read_en <= 1'b0;
      done         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_rows != '0) begin
              addr_reg     <= base_addr;
              rows_left    <= num_rows;
              sram_address <= base_addr;
              sram_read_en <= 1'b1;
              busy         <= 1'b1;
              state        <= ST_READ;
            end else begin
              done         <= 1'b1;
              state        <= ST_DONE;
            end
          end
        end
        ST_READ: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          out_valid <= 1'b1;
          state     <= ST_STREAM;
        end
        ST_STREAM: begin
          if (transfer && lane_wrap) begin
            rows_left <= rows_left - 1'b1;
            addr_reg  <= addr_reg + 1'b1;
            out_valid <= 1'b0;
            if (rows_left == ONE_ROW) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              sram_address <= addr_reg + 1'b1;
              sram_read_en <= 1'b1;
              state        <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_readback_ctrl.sv
// Directed self-checking bench for result_readback_ctrl with a one-cycle-latency SRAM model.
module tb_result_readback_ctrl;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [9:0]    base_addr;
  logic [10:0]   num_rows;
  logic          sram_read_en;
  logic [9:0]    sram_address;
  logic [383:0]  sram_rdata;
  logic [23:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_lane;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [383:0]  mem [0:1023];

  int n_checks;
  int n_pass;

  int beats, reads, dones, done_cyc, busy_at_done, busy_seen, hold_bad;
  logic [23:0] b_data [64];
  int          b_lane [64];
  logic        b_last [64];
  int          b_cyc  [64];
  int          rd_addr [8];
  int          rd_cyc  [8];
  int          stall_a, stall_b, mid_start_cyc;

  result_readback_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .base_addr    (base_addr),
    .num_rows     (num_rows),
    .sram_read_en (sram_read_en),
    .sram_address (sram_address),
    .sram_rdata   (sram_rdata),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lane     (out_lane),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_read_en) sram_rdata <= mem[sram_address];
  end

  function automatic logic [383:0] row_of(input int base);
    logic [383:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*24 +: 24] = 24'(base + i);
    return r;
  endfunction

  function automatic logic [383:0] signed_row();
    logic [383:0] r;
    r = '0;
    r[0*24 +: 24] = 24'h000001;
    r[2*24 +: 24] = 24'h800000;
    r[9*24 +: 24] = 24'hFFFFFF;
    return r;
  endfunction

  // Called right after an edge; returns one cycle later (cycle T+1 of the request).
  task automatic pulse_start(input int base, input int n);
    base_addr = 10'(base);
    num_rows  = 11'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Observes cycles T+1..T+max_cyc, acting as the consumer and recording reads, beats and done.
  task automatic collect(input int max_cyc);
    int cyc;
    int scnt;
    logic stalled;
    logic [28:0] held;
    beats = 0; reads = 0; dones = 0; done_cyc = -1; busy_at_done = -1;
    busy_seen = 0; hold_bad = 0;
    cyc = 1; scnt = 0; stalled = 1'b0; held = '0;
    while (cyc <= max_cyc) begin
      if (sram_read_en) begin
        if (reads < 8) begin
          rd_addr[reads] = int'(sram_address);
          rd_cyc[reads]  = cyc;
        end
        reads++;
      end
      if (done) begin
        dones++;
        done_cyc     = cyc;
        busy_at_done = int'(busy);
      end
      if (busy) busy_seen = 1;
      if (cyc == mid_start_cyc) begin
        base_addr = 10'd0;
        num_rows  = 11'd3;
        start     = 1'b1;
      end else begin
        start     = 1'b0;
      end
      if (out_valid) begin
        if (stalled && {out_lane, out_last, out_data} !== held) hold_bad++;
        if ((int'(out_lane) == stall_a || int'(out_lane) == stall_b) && scnt < 4) begin
          out_ready = 1'b0;
          held      = {out_lane, out_last, out_data};
          stalled   = 1'b1;
          scnt++;
        end else begin
          out_ready = 1'b1;
          if (beats < 64) begin
            b_data[beats] = out_data;
            b_lane[beats] = int'(out_lane);
            b_last[beats] = out_last;
            b_cyc[beats]  = cyc;
          end
          beats++;
          scnt    = 0;
          stalled = 1'b0;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({sram_read_en, sram_address, out_data, out_valid, out_lane, out_last, busy, done} !== 43'd0)
      $display("[TB] FAIL reset_outputs: got %h want 0",
               {sram_read_en, sram_address, out_data, out_valid, out_lane, out_last, busy, done});
    else n_pass++;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_row();
    int last_cnt;
    mem[5] = row_of(1);
    pulse_start(5, 1);
    collect(24);
    n_checks++;
    if (reads !== 1) $display("[TB] FAIL single_reads: got %0d want 1", reads); else n_pass++;
    n_checks++;
    if (rd_addr[0] !== 5 || rd_cyc[0] !== 1)
      $display("[TB] FAIL single_read_addr: got addr %0d cyc %0d want addr 5 cyc 1", rd_addr[0], rd_cyc[0]);
    else n_pass++;
    n_checks++;
    if (beats !== 16) $display("[TB] FAIL single_beats: got %0d want 16", beats); else n_pass++;
    last_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (b_data[i] !== 24'(i + 1) || b_lane[i] !== i || b_cyc[i] !== i + 3)
        $display("[TB] FAIL single_beat%0d: got data %h lane %0d cyc %0d want data %h lane %0d cyc %0d",
                 i, b_data[i], b_lane[i], b_cyc[i], 24'(i + 1), i, i + 3);
      else n_pass++;
      if (b_last[i] === 1'b1) last_cnt++;
    end
    n_checks++;
    if (last_cnt !== 1 || b_last[15] !== 1'b1)
      $display("[TB] FAIL single_last: got count %0d on_lane15 %b want 1 and 1", last_cnt, b_last[15]);
    else n_pass++;
    n_checks++;
    if (dones !== 1 || done_cyc !== 19 || busy_at_done !== 0)
      $display("[TB] FAIL single_done: got %0d pulses at %0d busy %0d want 1 at 19 busy 0",
               dones, done_cyc, busy_at_done);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    mem[5]  = row_of(1);
    stall_a = 3;
    stall_b = 15;
    pulse_start(5, 1);
    collect(32);
    stall_a = -1;
    stall_b = -1;
    n_checks++;
    if (beats !== 16) $display("[TB] FAIL bp_beats: got %0d want 16", beats); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (b_data[i] !== 24'(i + 1) || b_lane[i] !== i)
        $display("[TB] FAIL bp_beat%0d: got data %h lane %0d want data %h lane %0d",
                 i, b_data[i], b_lane[i], 24'(i + 1), i);
      else n_pass++;
    end
    n_checks++;
    if (hold_bad !== 0) $display("[TB] FAIL bp_hold: got %0d changes while stalled want 0", hold_bad);
    else n_pass++;
    n_checks++;
    if (b_cyc[3] !== 10 || b_cyc[15] !== 26)
      $display("[TB] FAIL bp_timing: got lane3 at %0d lane15 at %0d want 10 and 26", b_cyc[3], b_cyc[15]);
    else n_pass++;
    n_checks++;
    if (dones !== 1 || done_cyc !== 27)
      $display("[TB] FAIL bp_done: got %0d pulses at %0d want 1 at 27", dones, done_cyc);
    else n_pass++;
  endtask

  task automatic test_multi_row_wrap();
    int last_cnt;
    mem[1023] = row_of('h100);
    mem[0]    = row_of('h200);
    mem[1]    = row_of('h300);
    pulse_start(1023, 3);
    collect(60);
    n_checks++;
    if (reads !== 3) $display("[TB] FAIL wrap_reads: got %0d want 3", reads); else n_pass++;
    n_checks++;
    if (rd_addr[0] !== 1023 || rd_addr[1] !== 0 || rd_addr[2] !== 2 - 1)
      $display("[TB] FAIL wrap_addrs: got %0d %0d %0d want 1023 0 1", rd_addr[0], rd_addr[1], rd_addr[2]);
    else n_pass++;
    n_checks++;
    if (rd_cyc[0] !== 1 || rd_cyc[1] !== 19 || rd_cyc[2] !== 37)
      $display("[TB] FAIL wrap_read_cyc: got %0d %0d %0d want 1 19 37", rd_cyc[0], rd_cyc[1], rd_cyc[2]);
    else n_pass++;
    n_checks++;
    if (beats !== 48) $display("[TB] FAIL wrap_beats: got %0d want 48", beats); else n_pass++;
    last_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      n_checks++;
      if (b_data[i] !== 24'(256 * (i / 16 + 1) + i % 16) || b_lane[i] !== i % 16)
        $display("[TB] FAIL wrap_beat%0d: got data %h lane %0d want data %h lane %0d",
                 i, b_data[i], b_lane[i], 24'(256 * (i / 16 + 1) + i % 16), i % 16);
      else n_pass++;
      if (b_last[i] === 1'b1) last_cnt++;
    end
    n_checks++;
    if (b_cyc[16] - b_cyc[15] !== 3 || b_cyc[32] - b_cyc[31] !== 3)
      $display("[TB] FAIL wrap_gap: got %0d and %0d want 3 and 3", b_cyc[16] - b_cyc[15], b_cyc[32] - b_cyc[31]);
    else n_pass++;
    n_checks++;
    if (last_cnt !== 1 || b_last[47] !== 1'b1)
      $display("[TB] FAIL wrap_last: got count %0d final %b want 1 and 1", last_cnt, b_last[47]);
    else n_pass++;
    n_checks++;
    if (dones !== 1 || done_cyc !== 55)
      $display("[TB] FAIL wrap_done: got %0d pulses at %0d want 1 at 55", dones, done_cyc);
    else n_pass++;
  endtask

  task automatic test_zero_rows();
    pulse_start(9, 0);
    collect(6);
    n_checks++;
    if (dones !== 1 || done_cyc !== 1)
      $display("[TB] FAIL zero_done: got %0d pulses at %0d want 1 at 1", dones, done_cyc);
    else n_pass++;
    n_checks++;
    if (reads !== 0 || beats !== 0 || busy_seen !== 0)
      $display("[TB] FAIL zero_activity: got reads %0d beats %0d busy %0d want 0 0 0", reads, beats, busy_seen);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    mem[5]        = row_of(1);
    mid_start_cyc = 8;
    pulse_start(5, 1);
    collect(26);
    mid_start_cyc = -1;
    n_checks++;
    if (reads !== 1 || beats !== 16)
      $display("[TB] FAIL busy_start_ignored: got reads %0d beats %0d want 1 16", reads, beats);
    else n_pass++;
    n_checks++;
    if (dones !== 1 || done_cyc !== 19)
      $display("[TB] FAIL busy_start_done: got %0d pulses at %0d want 1 at 19", dones, done_cyc);
    else n_pass++;
  endtask

  task automatic test_signed_data();
    mem[7] = signed_row();
    pulse_start(7, 1);
    collect(24);
    n_checks++;
    if (b_data[2] !== 24'h800000 || b_data[9] !== 24'hFFFFFF)
      $display("[TB] FAIL signed_lanes: got lane2 %h lane9 %h want 800000 ffffff", b_data[2], b_data[9]);
    else n_pass++;
    n_checks++;
    if (b_data[0] !== 24'h000001 || b_data[3] !== 24'h000000 || b_data[10] !== 24'h000000)
      $display("[TB] FAIL signed_neighbours: got %h %h %h want 000001 000000 000000",
               b_data[0], b_data[3], b_data[10]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stream();
    mem[5] = row_of(1);
    mem[7] = signed_row();
    pulse_start(5, 1);
    repeat (9) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_lane !== 4'd7 || out_data !== 24'd8)
      $display("[TB] FAIL rst_pre_lane7: got valid %b lane %0d data %h want 1 7 000008", out_valid, out_lane, out_data);
    else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({sram_read_en, sram_address, out_data, out_valid, out_lane, out_last, busy, done} !== 43'd0)
      $display("[TB] FAIL rst_async_outputs: got %h want 0",
               {sram_read_en, sram_address, out_data, out_valid, out_lane, out_last, busy, done});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL rst_idle: got busy %b valid %b done %b want 0 0 0", busy, out_valid, done);
    else n_pass++;
    pulse_start(7, 1);
    collect(24);
    n_checks++;
    if (reads !== 1 || rd_addr[0] !== 7)
      $display("[TB] FAIL rst_restart_addr: got reads %0d addr %0d want 1 7", reads, rd_addr[0]);
    else n_pass++;
    n_checks++;
    if (beats !== 16 || b_data[2] !== 24'h800000 || dones !== 1 || done_cyc !== 19)
      $display("[TB] FAIL rst_restart_stream: got beats %0d lane2 %h dones %0d at %0d want 16 800000 1 19",
               beats, b_data[2], dones, done_cyc);
    else n_pass++;
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    start         = 1'b0;
    base_addr     = '0;
    num_rows      = '0;
    out_ready     = 1'b1;
    stall_a       = -1;
    stall_b       = -1;
    mid_start_cyc = -1;
    rstn          = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_single_row();
    test_backpressure();
    test_multi_row_wrap();
    test_zero_rows();
    test_start_while_busy();
    test_signed_data();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_readback_ctrl.md
Name: result_readback_ctrl

Overview:
- Reader for the systolic result SRAM: the array writes one 16-lane row of 24-bit partial sums per address; this block reads those rows back.
- On start, reads num_rows consecutive rows from base_addr and serializes each row lane by lane onto a valid/ready output stream for the host/DMA side.
- Sits between the result SRAM read port and the host interface. Port arbitration against the writer is external.

Parameters:
- ADDRESSSIZE, 10: result SRAM address width.
- PARTIAL_SUM_BW, 24: width of one result lane.
- MATRIX_SIZE, 16: lanes per SRAM row; must be a power of 2.
- LANE_BW, 4: lane index width, equal to log2(MATRIX_SIZE).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDRESSSIZE  first row address; captured on accepted start.
- num_rows  in  ADDRESSSIZE+1  rows to read; captured on accepted start.
- sram_read_en  out  1  read strobe to result SRAM.
- sram_address  out  ADDRESSSIZE  read address.
- sram_rdata  in  PARTIAL_SUM_BW*MATRIX_SIZE  SRAM read data; valid the cycle after the address is presented.
- out_data  out  PARTIAL_SUM_BW  current lane value (raw two's-complement bits).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the beat.
- out_lane  out  LANE_BW  lane index of out_data.
- out_last  out  1  high on the final lane of the final row.
- busy  out  1  high from accepted start until the done cycle (exclusive).
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE. All outputs are 0, including out_data and sram_address. Row register, row counter and lane counter are cleared.
- Reset mid-operation aborts immediately. No done pulse. The in-flight beat is dropped.
- States: IDLE, READ, CAPTURE, STREAM, DONE.
- IDLE:
  - start=1 with num_rows!=0: capture base_addr into addr_reg and num_rows into rows_left, then go to READ.
  - start=1 with num_rows==0: go directly to DONE. No SRAM access, no beats.
  - start while not in IDLE is ignored.
- READ (1 cycle): sram_read_en=1, sram_address=addr_reg. Go to CAPTURE.
- CAPTURE (1 cycle): latch sram_rdata into row_reg at the cycle end. Clear the lane counter. Go to STREAM.
- STREAM:
  - out_valid=1, out_data=row_reg[lane*PARTIAL_SUM_BW +: PARTIAL_SUM_BW], with lane 0 at bits [23:0].
  - A beat transfers when out_valid && out_ready. The lane counter increments only on a transfer.
  - While out_ready=0, out_data, out_lane and out_last hold stable.
  - Transfer of lane MATRIX_SIZE-1: decrement rows_left and increment addr_reg (wraps modulo 2^ADDRESSSIZE). If rows_left was 1, go to DONE; otherwise go to READ.
- DONE (1 cycle): done=1, busy=0, out_valid=0, then IDLE.
- sram_read_en is 0 outside READ. sram_address holds its last value.
- Latency:
  - start accepted at cycle T gives READ at T+1, CAPTURE at T+2, first beat valid at T+3.
  - Each row costs 2 overhead cycles plus MATRIX_SIZE beats with out_ready held high.
  - N rows with ready held high finish with done at cycle T+3+N*(MATRIX_SIZE+2)-2.
- out_last = STREAM && rows_left==1 && lane==MATRIX_SIZE-1.
- Maximum num_rows is 2^ADDRESSSIZE. Larger values are truncated to ADDRESSSIZE+1 bits by the port width and otherwise honoured (address wraps).

Decomposition:
- Shared header/package holds:
  - default constants ADDRESSSIZE, PARTIAL_SUM_BW, MATRIX_SIZE, LANE_BW;
  - state encodings ST_IDLE, ST_READ, ST_CAPTURE, ST_STREAM, ST_DONE.
- One sub-module: result_lane_serializer.
  - Holds row_reg and the lane counter; muxes the lane slice.
  - Generates the lane-wrap indication.
  - The FSM and address/row counters stay in result_readback_ctrl.

Test Plan:
- Reset mid-stream: assert rstn low during lane 7 of row 0 -> all outputs 0 asynchronously; after release, state IDLE; a new start restarts from the new base_addr.
- Single row, ready tied high: SRAM row 5 holds lane i = i+1; start with base_addr=5, num_rows=1 at T -> sram_read_en=1 with address 5 at T+1; beats 1..16 at T+3..T+18; out_last only at T+18; done at T+19.
- Backpressure: same setup, out_ready=0 at lanes 3 and 15 for 4 cycles each -> out_data holds 4 and 16 respectively; no lane skipped or duplicated; done 8 cycles later than the ready-high case.
- Multi-row with wrap: base_addr=1023, num_rows=3 -> read addresses 1023, 0, 1 in order; 48 beats; 2 idle cycles between rows; a single done pulse.
- Zero rows and start-while-busy: num_rows=0 -> done the cycle after start, no sram_read_en, no beats. A start pulsed mid-stream is ignored and the row count is unchanged.
- Signed data: lane values 24'h800000 and 24'hFFFFFF -> emitted bit-exact in the correct lane positions.
